// File: rtl/display_pkg.sv
// Shared types and constants for the display timing generator.
package display_pkg;

  localparam int CNT_W        = 10;
  localparam int PIX_PER_WORD = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    HBLANK,
    VBLANK
  } state_t;

  // Frame geometry, captured at frame start so mid-frame input changes are ignored.
  typedef struct packed {
    logic [CNT_W-1:0] hb;
    logic [CNT_W-1:0] vb;
    logic [CNT_W-1:0] aip;
    logic [CNT_W-1:0] ail;
  } cfg_t;

  function automatic logic cfg_valid(input logic [CNT_W-1:0] aip,
                                     input logic [CNT_W-1:0] ail);
    return (aip != '0) && (ail != '0);
  endfunction

endpackage

// File: rtl/display_timing_gen_word_unpacker.sv
// Serialises 32-bit FIFO words into PIX_W-bit pixels, MSB first, and
// generates the show-ahead FIFO pop strobe.
module word_unpacker
  import display_pkg::*;
#(
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             active,
  input  logic             line_last,
  input  logic             tpg_on,
  input  logic [PIX_W-1:0] tpg_pixel,
  input  logic [31:0]      fifo_rdata,
  input  logic             fifo_empty,
  output logic             fifo_rd,
  output logic [PIX_W-1:0] pixel,
  output logic             starved
);

  localparam int IDX_W = $clog2(PIX_PER_WORD);

  logic [IDX_W-1:0] byte_idx;
  logic [PIX_W-1:0] word_pixel;

  // Byte index restarts at every line start, dropping leftovers of a partial word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_idx <= '0;
    end else if (active && !line_last) begin
      byte_idx <= byte_idx + 1'b1;
    end else begin
      byte_idx <= '0;
    end
  end

  always_comb begin
    word_pixel = fifo_rdata[31 -: PIX_W];
    for (int i = 0; i < PIX_PER_WORD; i++) begin
      if (byte_idx == IDX_W'(i)) begin
        word_pixel = fifo_rdata[31 - i*PIX_W -: PIX_W];
      end
    end
  end

  // An empty FIFO yields a black pixel and is never popped.
  always_comb begin
    fifo_rd = 1'b0;
    pixel   = '0;
    starved = 1'b0;
    if (active) begin
      if (tpg_on) begin
        pixel = tpg_pixel;
      end else if (fifo_empty) begin
        starved = 1'b1;
      end else begin
        pixel   = word_pixel;
        fifo_rd = (byte_idx == IDX_W'(PIX_PER_WORD - 1)) || line_last;
      end
    end
  end

endmodule

// File: rtl/display_timing_gen.sv
// Display timing generator: HSync/VSync/DE framing around unpacked FIFO pixels.
// Optional test pattern generator enabled by defining DISPLAY_TPG_EN.
module display_timing_gen #(
  parameter int PIX_W = 8,
  parameter int CNT_W = display_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             CSDisplay,
  input  logic [CNT_W-1:0] HB_in,
  input  logic [CNT_W-1:0] VB_in,
  input  logic [CNT_W-1:0] AIP_in,
  input  logic [CNT_W-1:0] AIL_in,
  input  logic [31:0]      fifo_rdata,
  input  logic             fifo_empty,
  output logic             fifo_rd,
  input  logic             tpg_sel,
  output logic             HSync,
  output logic             VSync,
  output logic             DE,
  output logic [PIX_W-1:0] Pixel,
  output logic             frame_done,
  output logic             underflow,
  output logic             config_err
);

  import display_pkg::*;

  state_t           state, state_nx;
  logic [CNT_W-1:0] hcnt, hcnt_nx;
  logic [CNT_W-1:0] vcnt, vcnt_nx;
  logic             vphase, vphase_nx;
  cfg_t             cfg;
  logic             start_ok, load_cfg, wrap, line_end, vline_end;
  logic             tpg_on, starved, line_last;
  logic [PIX_W-1:0] tpg_pixel, pix;

  assign start_ok  = CSDisplay && cfg_valid(AIP_in, AIL_in);
  assign line_last = (state == ACTIVE) && (hcnt == cfg.aip - 1'b1);

`ifdef DISPLAY_TPG_EN
  logic tpg_lat;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tpg_lat <= 1'b0;
    end else if (load_cfg) begin
      tpg_lat <= tpg_sel;
    end
  end

  assign tpg_on    = tpg_lat;
  assign tpg_pixel = PIX_W'(hcnt[7:0] ^ vcnt[7:0]);
`else
  logic unused_tpg_sel;

  assign unused_tpg_sel = tpg_sel;
  assign tpg_on         = 1'b0;
  assign tpg_pixel      = '0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      hcnt   <= '0;
      vcnt   <= '0;
      vphase <= 1'b0;
      cfg    <= '0;
    end else begin
      state  <= state_nx;
      hcnt   <= hcnt_nx;
      vcnt   <= vcnt_nx;
      vphase <= vphase_nx;
      if (load_cfg) begin
        cfg.hb  <= HB_in;
        cfg.vb  <= VB_in;
        cfg.aip <= AIP_in;
        cfg.ail <= AIL_in;
      end
    end
  end

  // In VBLANK, vphase splits each line into its active-length part and the HB tail.
  always_comb begin
    state_nx  = state;
    hcnt_nx   = hcnt + 1'b1;
    vcnt_nx   = vcnt;
    vphase_nx = vphase;
    load_cfg  = 1'b0;
    wrap      = 1'b0;
    line_end  = 1'b0;
    vline_end = 1'b0;
    case (state)
      IDLE: begin
        hcnt_nx = '0;
        vcnt_nx = '0;
        if (start_ok) begin
          state_nx = ACTIVE;
          load_cfg = 1'b1;
        end
      end
      ACTIVE: begin
        if (line_last) begin
          if (cfg.hb != '0) begin
            state_nx = HBLANK;
            hcnt_nx  = '0;
          end else begin
            line_end = 1'b1;
          end
        end
      end
      HBLANK: begin
        if (hcnt == cfg.hb - 1'b1) line_end = 1'b1;
      end
      VBLANK: begin
        if (!vphase) begin
          if (hcnt == cfg.aip - 1'b1) begin
            if (cfg.hb != '0) begin
              vphase_nx = 1'b1;
              hcnt_nx   = '0;
            end else begin
              vline_end = 1'b1;
            end
          end
        end else if (hcnt == cfg.hb - 1'b1) begin
          vline_end = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase

    if (line_end) begin
      hcnt_nx = '0;
      if (vcnt == cfg.ail - 1'b1) begin
        if (cfg.vb != '0) begin
          state_nx  = VBLANK;
          vcnt_nx   = '0;
          vphase_nx = 1'b0;
        end else begin
          wrap = 1'b1;
        end
      end else begin
        state_nx = ACTIVE;
        vcnt_nx  = vcnt + 1'b1;
      end
    end

    if (vline_end) begin
      hcnt_nx   = '0;
      vphase_nx = 1'b0;
      if (vcnt == cfg.vb - 1'b1) wrap = 1'b1;
      else vcnt_nx = vcnt + 1'b1;
    end

    if (wrap) begin
      hcnt_nx   = '0;
      vcnt_nx   = '0;
      vphase_nx = 1'b0;
      if (start_ok) begin
        state_nx = ACTIVE;
        load_cfg = 1'b1;
      end else begin
        state_nx = IDLE;
      end
    end
  end

  word_unpacker #(.PIX_W(PIX_W)) u_unpacker (
    .clk       (clk),
    .reset     (reset),
    .active    (state == ACTIVE),
    .line_last (line_last),
    .tpg_on    (tpg_on),
    .tpg_pixel (tpg_pixel),
    .fifo_rdata(fifo_rdata),
    .fifo_empty(fifo_empty),
    .fifo_rd   (fifo_rd),
    .pixel     (pix),
    .starved   (starved)
  );

  // Panel outputs trail the state/counter cycle by one clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      HSync      <= 1'b0;
      VSync      <= 1'b0;
      DE         <= 1'b0;
      Pixel      <= '0;
      frame_done <= 1'b0;
      underflow  <= 1'b0;
      config_err <= 1'b0;
    end else begin
      HSync      <= (state == HBLANK) || ((state == VBLANK) && vphase);
      VSync      <= (state == VBLANK);
      DE         <= (state == ACTIVE);
      Pixel      <= pix;
      frame_done <= wrap;
      underflow  <= underflow || starved;
      config_err <= CSDisplay && !cfg_valid(AIP_in, AIL_in);
    end
  end

endmodule

// File: tb/tb_display_timing_gen.sv
// Scoreboard bench for display_timing_gen; reference model derives every output
// from the frame position (line = p / line_len, col = p % line_len).
module tb_display_timing_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        CSDisplay = 1'b0;
  logic [9:0]  HB_in = '0, VB_in = '0, AIP_in = '0, AIL_in = '0;
  logic [31:0] fifo_rdata;
  logic        fifo_empty = 1'b0;
  logic        fifo_rd;
  logic        tpg_sel = 1'b0;
  logic        HSync, VSync, DE, frame_done, underflow, config_err;
  logic [7:0]  Pixel;

  display_timing_gen #(.PIX_W(8), .CNT_W(10)) dut (
    .clk(clk), .reset(reset), .CSDisplay(CSDisplay),
    .HB_in(HB_in), .VB_in(VB_in), .AIP_in(AIP_in), .AIL_in(AIL_in),
    .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd),
    .tpg_sel(tpg_sel), .HSync(HSync), .VSync(VSync), .DE(DE), .Pixel(Pixel),
    .frame_done(frame_done), .underflow(underflow), .config_err(config_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       de;
    logic       hs;
    logic       vs;
    logic [7:0] pix;
    logic       fd;
    logic       uf;
    logic       ce;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  // FIFO environment: fixed word sequence, head advances on accepted pops.
  logic [31:0] words [1024];
  logic [9:0]  hd = '0;
  assign fifo_rdata = words[hd];

  always @(posedge clk) begin
    if (fifo_rd && !fifo_empty) hd <= hd + 1'b1;
  end

  // Values the driver copies onto DUT inputs at each falling edge.
  logic drv_reset = 1'b0, drv_cs = 1'b0, drv_tpg = 1'b0;
  int   drv_hb = 0, drv_vb = 0, drv_aip = 0, drv_ail = 0;
  int   empty_mode = 0;

  // Reference model state.
  bit         running = 0;
  bit         uf_m = 0;
  bit         m_tpg = 0;
  int         p = 0;
  int         m_hb = 0, m_vb = 0, m_aip = 0, m_ail = 0;
  logic [9:0] mk = '0;

  task automatic latch_cfg();
    m_hb  = int'(HB_in);
    m_vb  = int'(VB_in);
    m_aip = int'(AIP_in);
    m_ail = int'(AIL_in);
`ifdef DISPLAY_TPG_EN
    m_tpg = tpg_sel;
`else
    m_tpg = 0;
`endif
  endtask

  task automatic apply_stimulus();
    exp_t e;
    bit   exp_rd;
    int   len, frame_len, line, col;
    bit   act;
    @(negedge clk);
    reset     = drv_reset;
    CSDisplay = drv_cs;
    tpg_sel   = drv_tpg;
    HB_in     = 10'(drv_hb);
    VB_in     = 10'(drv_vb);
    AIP_in    = 10'(drv_aip);
    AIL_in    = 10'(drv_ail);
    fifo_empty = 1'b0;
    if (running) begin
      len = m_aip + m_hb;
      if (empty_mode == 1 && (p / len) == 0 && (p % len) >= 2 && (p % len) <= 4)
        fifo_empty = 1'b1;
    end
    if (empty_mode == 2 && $urandom_range(0, 7) == 0) fifo_empty = 1'b1;
    #1;
    e = '0;
    exp_rd = 0;
    if (!reset) begin
      running = 0;
      uf_m = 0;
    end else begin
      e.ce = CSDisplay && (AIP_in == 0 || AIL_in == 0);
      if (running) begin
        len = m_aip + m_hb;
        frame_len = (m_ail + m_vb) * len;
        line = p / len;
        col = p % len;
        act = (line < m_ail) && (col < m_aip);
        e.de = act;
        e.hs = (col >= m_aip);
        e.vs = (line >= m_ail);
        e.fd = (p == frame_len - 1);
        if (act) begin
          if (m_tpg) begin
            e.pix = 8'((col ^ line) & 255);
          end else if (fifo_empty) begin
            uf_m = 1;
          end else begin
            e.pix = 8'((words[mk] >> (24 - 8 * (col % 4))) & 32'hff);
            exp_rd = (col % 4 == 3) || (col == m_aip - 1);
          end
        end
        p++;
        if (p == frame_len) begin
          p = 0;
          if (CSDisplay && AIP_in != 0 && AIL_in != 0) latch_cfg();
          else running = 0;
        end
      end else if (CSDisplay && AIP_in != 0 && AIL_in != 0) begin
        latch_cfg();
        running = 1;
        p = 0;
      end
      e.uf = uf_m;
    end
    checks++;
    if (fifo_rd !== exp_rd) begin
      failures++;
      $display("[TB] FAIL fifo_rd t=%0t got=%b expected=%b", $time, fifo_rd, exp_rd);
    end
    if (exp_rd) mk = mk + 1'b1;
    sb.push_back(e);
  endtask

  task automatic check_output();
    exp_t e, a;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      a = '{de: DE, hs: HSync, vs: VSync, pix: Pixel, fd: frame_done,
            uf: underflow, ce: config_err};
      checks++;
      if (a !== e) begin
        failures++;
        $display("[TB] FAIL outputs t=%0t got de=%b hs=%b vs=%b pix=%h fd=%b uf=%b ce=%b expected de=%b hs=%b vs=%b pix=%h fd=%b uf=%b ce=%b",
                 $time, a.de, a.hs, a.vs, a.pix, a.fd, a.uf, a.ce,
                 e.de, e.hs, e.vs, e.pix, e.fd, e.uf, e.ce);
      end
    end
  endtask

  always @(posedge clk) begin
    #1;
    check_output();
  end

  task automatic run(input int n);
    repeat (n) apply_stimulus();
  endtask

  initial begin
    for (int k = 0; k < 1024; k++) begin
      if (k < 16) words[k] = {8'(4*k+1), 8'(4*k+2), 8'(4*k+3), 8'(4*k+4)};
      else words[k] = $urandom;
    end
    drv_hb = 4; drv_vb = 1; drv_aip = 8; drv_ail = 2;
    #2 reset = 1'b0;
    run(4);

    // Directed geometry: 36-clock frames.
    drv_reset = 1'b1;
    drv_cs = 1'b1;
    run(36 * 3 + 2);

    // Partial words: 6 pixels per line.
    drv_aip = 6;
    run(36 + 30 * 2);

    // FIFO empty for the 3rd-5th active pixels of a line.
    empty_mode = 1;
    run(60);
    empty_mode = 0;
    run(10);

    // Asynchronous reset mid-frame clears everything at once.
    @(posedge clk);
    #3;
    reset = 1'b0;
    drv_reset = 1'b0;
    #1;
    checks++;
    if ({DE, HSync, VSync, Pixel, frame_done, underflow, config_err, fifo_rd} !== '0) begin
      failures++;
      $display("[TB] FAIL async_reset got de=%b hs=%b vs=%b pix=%h fd=%b uf=%b ce=%b rd=%b expected all zero",
               DE, HSync, VSync, Pixel, frame_done, underflow, config_err, fifo_rd);
    end
    run(3);
    drv_reset = 1'b1;
    run(20);

    // Size change plus disable mid-frame: frame completes, then idle.
    drv_aip = 3;
    drv_cs = 1'b0;
    run(60);

    // Zero line count while enabled.
    drv_ail = 0;
    drv_cs = 1'b1;
    run(10);

    // No horizontal or vertical blanking.
    drv_ail = 1; drv_aip = 4; drv_hb = 0; drv_vb = 0;
    run(20);

    // Randomised geometry, FIFO starvation and test-pattern select.
    empty_mode = 2;
    repeat (8) begin
      drv_aip = $urandom_range(1, 20);
      drv_hb  = $urandom_range(0, 5);
      drv_ail = $urandom_range(1, 4);
      drv_vb  = $urandom_range(0, 3);
      drv_tpg = 1'($urandom_range(0, 1));
      run(150);
    end
    empty_mode = 0;
    drv_cs = 1'b0;
    run(5);

    @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/display_timing_gen.md
Name: display_timing_gen

Overview:
- Sits directly downstream of DataPath in the display adapter.
- Pulls 32-bit pixel words from DataPath's show-ahead pixel FIFO and serialises each word into four 8-bit pixels.
- Wraps the pixel stream in display timing (HSync, VSync, DE) built from the blanking and active-size values (HB, VB, AIP, AIL) that DataPath also receives.
- Its outputs drive the panel interface.

Parameters:
- PIX_W, 8, pixel width in bits; 32/PIX_W pixels per FIFO word.
- CNT_W, 10, width of the timing configuration values and of the counters.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- CSDisplay  in  1  display enable; level-sensitive.
- HB_in  in  CNT_W  horizontal blank length, in clocks.
- VB_in  in  CNT_W  vertical blank length, in lines.
- AIP_in  in  CNT_W  active pixels per line.
- AIL_in  in  CNT_W  active lines per frame.
- fifo_rdata  in  32  head FIFO word; valid whenever fifo_empty=0.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd  out  1  pop strobe; combinational, same cycle the head word is consumed.
- tpg_sel  in  1  test-pattern select; used only with the optional feature.
- HSync  out  1  high during horizontal blank.
- VSync  out  1  high during vertical blank lines.
- DE  out  1  data enable; high on active pixels.
- Pixel  out  PIX_W  pixel value.
- frame_done  out  1  one-cycle pulse on the last cycle of each frame.
- underflow  out  1  sticky FIFO-underflow flag.
- config_err  out  1  high while enabled but AIP_in=0 or AIL_in=0.

Behaviour:
- Reset state: all outputs 0, FSM in IDLE, counters 0, shadow config 0, byte index 0.
- Shadow config: HB/VB/AIP/AIL are latched on IDLE exit and on every frame wrap. Mid-frame input changes are ignored.
- FSM states: IDLE, ACTIVE, HBLANK, VBLANK.
  - IDLE -> ACTIVE when CSDisplay=1, AIP_in!=0 and AIL_in!=0.
  - If CSDisplay=1 but a size is 0: stay in IDLE, config_err=1.
  - ACTIVE: hcnt runs 0..AIP-1, then HBLANK (or, if HB=0, directly to the next line).
  - HBLANK: hcnt runs 0..HB-1. After the line, vcnt increments. If vcnt reaches AIL, go to VBLANK, or to frame wrap if VB=0.
  - VBLANK: VB lines, each AIP+HB clocks long. HSync=1 during the final HB clocks of each line.
  - Frame wrap: frame_done=1 on the last cycle. If CSDisplay=1, reload the shadow config and go to ACTIVE. Otherwise go to IDLE.
- CSDisplay deasserting mid-frame has no effect until frame wrap; the current frame completes.
- Output latency: HSync/VSync/DE/Pixel are registered, one clock after the state/counter cycle that produces them. frame_done is aligned with the registered outputs.
- Word unpacking:
  - Byte index 0..3; pixel 0 = fifo_rdata[31:24], MSB-first.
  - fifo_rd=1 in the ACTIVE cycle that uses byte index 3, and also on the last active pixel of a line (partial word).
  - The byte index resets to 0 at every line start. Leftover pixels of a partial word are discarded.
- Underflow: if an ACTIVE cycle needs data while fifo_empty=1:
  - Pixel=0 and DE=1 still.
  - fifo_rd=0 (never pop an empty FIFO).
  - underflow is set and cleared only by reset.
  - Timing is unaffected.
- Pixel=0 whenever DE=0.
- Counters are per-phase, so no CNT_W overflow for any legal config.

Optional Feature:
- Macro: DISPLAY_TPG_EN.
- Defined: when tpg_sel=1 at frame start (latched with the config), active pixels are hcnt[7:0] ^ vcnt[7:0], fifo_rd stays 0, and underflow cannot set for that frame.
- Undefined: tpg_sel is ignored, no TPG logic is synthesised.

Decomposition:
- Shared package display_pkg holds:
  - the state enum (IDLE, ACTIVE, HBLANK, VBLANK);
  - PIX_PER_WORD = 4;
  - CNT_W;
  - a struct for the HB/VB/AIP/AIL shadow config.
- One natural sub-module: word_unpacker (byte index, pixel mux, fifo_rd generation). The FSM and counters stay in the top module.

Test Plan:
- Reset: hold reset=0 mid-frame -> all outputs 0 immediately, asynchronously. Release with CSDisplay=1 -> first DE on clock 2 after release.
- AIP=8, HB=4, AIL=2, VB=1, full FIFO holding 0x01020304, 0x05060708, ...:
  - Pixel sequence is 01..08 with DE high 8 clocks, then HSync high 4 clocks.
  - 2 fifo_rd pulses per line.
  - VSync high for 12 clocks.
  - frame_done pulses every 36 clocks.
- AIP=6: second word pops after 2 pixels; 2 pixels are discarded; the next line starts at byte 0 of a fresh word.
- FIFO empty for cycles 3-5 of ACTIVE -> Pixel=0 with DE=1, no fifo_rd, underflow=1 and stays set. Timing is unchanged.
- Change AIP_in mid-frame and drop CSDisplay -> the current frame completes with the old size, then IDLE. AIL_in=0 with CSDisplay=1 -> config_err=1, no DE.
- DISPLAY_TPG_EN, tpg_sel=1 -> pixel at hcnt=5, vcnt=3 is 0x06 and fifo_rd never asserts.
